// File: rtl/aon_clk_rst_gen.sv
// aon_clk_rst_gen: always-on clock/reset generator for the safe domain.
// Produces NUM_CH glitch-free divided clocks from ref_clk_i, with runtime
// divide updates through a valid/ack handshake, and releases per-domain
// active-low resets one after another after reset deassertion.
//
// Optional DFT bypass, enabled by defining AON_CLKGEN_TEST_BYPASS_EN:
// while test_mode_i=1, clk_o[k]=ref_clk_i and rst_no[k]=~rst_i.
//
// state     | meaning
// SEQ_RESET | rst_i asserted, all domain resets held low
// SEQ_DELAY | counting RST_DLY cycles before releasing rst_no[idx]
// SEQ_DONE  | all domain resets released, busy_o low

`ifdef AON_CLKGEN_TEST_BYPASS_EN
// Behavioural view of the glitch-free clock mux cell; sel_i is a static
// DFT control, so the switch only happens while the design is quiescent.
module aon_clk_gmux (
  input  logic clk0_i,
  input  logic clk1_i,
  input  logic sel_i,
  output logic clk_o
);
  assign clk_o = sel_i ? clk1_i : clk0_i;
endmodule
`endif

module aon_clk_rst_gen #(
  parameter int NUM_CH        = 3,
  parameter int DIV_WIDTH     = 16,
  parameter int DIV_RST       = 0,
  parameter int RST_DLY       = 16,
  parameter int RST_DLY_WIDTH = 8
) (
  input  logic                        ref_clk_i,
  input  logic                        rst_i,
  input  logic                        test_mode_i,
  input  logic [NUM_CH*DIV_WIDTH-1:0] div_i,
  input  logic [NUM_CH-1:0]           div_valid_i,
  output logic [NUM_CH-1:0]           div_ack_o,
  input  logic [NUM_CH-1:0]           clk_en_i,
  output logic [NUM_CH-1:0]           clk_o,
  output logic [NUM_CH-1:0]           rst_no,
  output logic                        busy_o
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0] div_clk;

  // ---------------------------------------------------------------------
  // Per-channel divider with shadowed ratio update
  // ---------------------------------------------------------------------
  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic [DIV_WIDTH-1:0] div_q;
    logic [DIV_WIDTH-1:0] shadow_q;
    logic [DIV_WIDTH-1:0] cnt_q;
    logic                 pend_q;
    logic                 clk_q;
    logic                 ack_q;
    logic                 running;
    logic                 at_max;
    logic                 apply;

    // A channel keeps counting while enabled or while a high phase is still
    // in flight; once low with enable off it is stopped and cnt is parked at 0.
    assign running = clk_en_i[k] | clk_q;
    assign at_max  = (cnt_q == div_q);
    // Running: swap only on the falling edge closing a full period, so no
    // short pulse is ever produced. Stopped: swap on the next cycle.
    assign apply   = pend_q & (running ? (at_max & clk_q) : 1'b1);

    // Counter, output flop, shadow/pending handshake and ack pulse.
    always_ff @(posedge ref_clk_i or posedge rst_i) begin
      if (rst_i) begin
        div_q    <= DIV_WIDTH'(DIV_RST);
        shadow_q <= DIV_WIDTH'(DIV_RST);
        cnt_q    <= '0;
        pend_q   <= 1'b0;
        clk_q    <= 1'b0;
        ack_q    <= 1'b0;
      end else begin
        ack_q <= apply;
        if (!running) begin
          cnt_q <= '0;
        end else if (at_max) begin
          cnt_q <= '0;
          clk_q <= ~clk_q;
        end else begin
          cnt_q <= cnt_q + DIV_WIDTH'(1);
        end
        if (apply) begin
          div_q <= shadow_q;
        end
        // A request arriving on an apply cycle stays pending for the next one.
        if (div_valid_i[k]) begin
          shadow_q <= div_i[k*DIV_WIDTH +: DIV_WIDTH];
          pend_q   <= 1'b1;
        end else if (apply) begin
          pend_q <= 1'b0;
        end
      end
    end

    assign div_clk[k]   = clk_q;
    assign div_ack_o[k] = ack_q;
  end

  // ---------------------------------------------------------------------
  // Reset release sequencer
  // ---------------------------------------------------------------------
  typedef enum logic [1:0] {
    SEQ_RESET = 2'd0,
    SEQ_DELAY = 2'd1,
    SEQ_DONE  = 2'd2
  } seq_state_t;

  seq_state_t               state_q, state_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [RST_DLY_WIDTH-1:0] dly_q, dly_d;
  logic [NUM_CH-1:0]        rst_n_q, rst_n_d;
  logic                     busy_q, busy_d;

  // Sequencer state register.
  always_ff @(posedge ref_clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= SEQ_RESET;
      idx_q   <= '0;
      dly_q   <= '0;
      rst_n_q <= '0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      dly_q   <= dly_d;
      rst_n_q <= rst_n_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state logic: release one domain every RST_DLY cycles.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    dly_d   = dly_q;
    rst_n_d = rst_n_q;
    busy_d  = busy_q;
    case (state_q)
      SEQ_RESET: begin
        state_d = SEQ_DELAY;
        idx_d   = '0;
        dly_d   = '0;
      end
      SEQ_DELAY: begin
        if (dly_q == RST_DLY_WIDTH'(RST_DLY - 1)) begin
          dly_d = '0;
          for (int i = 0; i < NUM_CH; i++) begin
            if (idx_q == IDX_W'(i)) begin
              rst_n_d[i] = 1'b1;
            end
          end
          if (idx_q == IDX_W'(NUM_CH - 1)) begin
            state_d = SEQ_DONE;
            busy_d  = 1'b0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          dly_d = dly_q + RST_DLY_WIDTH'(1);
        end
      end
      SEQ_DONE: begin
        busy_d = 1'b0;
      end
      default: begin
        state_d = SEQ_RESET;
      end
    endcase
  end

  assign busy_o = busy_q;

  // ---------------------------------------------------------------------
  // Output stage
  // ---------------------------------------------------------------------
`ifdef AON_CLKGEN_TEST_BYPASS_EN
  for (genvar k = 0; k < NUM_CH; k++) begin : g_bypass
    aon_clk_gmux u_gmux (
      .clk0_i (div_clk[k]),
      .clk1_i (ref_clk_i),
      .sel_i  (test_mode_i),
      .clk_o  (clk_o[k])
    );
  end
  assign rst_no = test_mode_i ? {NUM_CH{~rst_i}} : rst_n_q;
`else
  logic unused_test_mode;
  assign unused_test_mode = test_mode_i;
  assign clk_o  = div_clk;
  assign rst_no = rst_n_q;
`endif

endmodule

// File: tb/tb_aon_clk_rst_gen.sv
// Bench for aon_clk_rst_gen with default parameters (NUM_CH=3, DIV_RST=0,
// RST_DLY=16). Reset sequencing, divide tables, enable gating and a random
// ratio-update run checked against a period/phase reference model.
module tb_aon_clk_rst_gen;
  localparam int NUM_CH  = 3;
  localparam int DW      = 16;
  localparam int RST_DLY = 16;

  logic                   ref_clk_i = 1'b0;
  logic                   rst_i = 1'b0;
  logic                   test_mode_i = 1'b0;
  logic [NUM_CH*DW-1:0]   div_i = '0;
  logic [NUM_CH-1:0]      div_valid_i = '0;
  logic [NUM_CH-1:0]      div_ack_o;
  logic [NUM_CH-1:0]      clk_en_i = '1;
  logic [NUM_CH-1:0]      clk_o;
  logic [NUM_CH-1:0]      rst_no;
  logic                   busy_o;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int ack_cnt [NUM_CH];

  typedef struct {
    int div;
    int exp_period;
  } vec_t;
  vec_t tbl [6];

  int lat, lo, hi, e0, d, t0, p, n, a, v, gap, base, cur_d;
  logic flag;

  aon_clk_rst_gen #(
    .NUM_CH        (NUM_CH),
    .DIV_WIDTH     (DW),
    .DIV_RST       (0),
    .RST_DLY       (RST_DLY),
    .RST_DLY_WIDTH (8)
  ) dut (
    .ref_clk_i   (ref_clk_i),
    .rst_i       (rst_i),
    .test_mode_i (test_mode_i),
    .div_i       (div_i),
    .div_valid_i (div_valid_i),
    .div_ack_o   (div_ack_o),
    .clk_en_i    (clk_en_i),
    .clk_o       (clk_o),
    .rst_no      (rst_no),
    .busy_o      (busy_o)
  );

  always #5 ref_clk_i = ~ref_clk_i;

  always @(posedge ref_clk_i) cyc++;

  always @(negedge ref_clk_i) begin
    for (int k = 0; k < NUM_CH; k++) begin
      if (div_ack_o[k] === 1'b1) ack_cnt[k]++;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, bad=%0d", bad);
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge ref_clk_i);
    #1;
  endtask

  task automatic request(input int ch, input int val);
    div_i[ch*DW +: DW] = val[DW-1:0];
    div_valid_i[ch] = 1'b1;
    tick();
    div_valid_i[ch] = 1'b0;
  endtask

  task automatic wait_ack(input int ch, input int bound, output int l);
    l = -1;
    for (int i = 1; i <= bound; i++) begin
      tick();
      if (div_ack_o[ch] === 1'b1) begin
        l = i;
        break;
      end
    end
  endtask

  task automatic measure_run(input int ch, input logic level, input int bound, output int len);
    len = -1;
    for (int i = 1; i <= bound; i++) begin
      tick();
      if (clk_o[ch] !== level) begin
        len = i;
        break;
      end
    end
  endtask

  // Sample j is taken just after edge E0+j; all channels at D=0, enabled.
  task automatic seq_check(input int cnt);
    logic [NUM_CH-1:0] exp_rst;
    for (int j = 0; j < cnt; j++) begin
      tick();
      for (int k = 0; k < NUM_CH; k++) exp_rst[k] = (j >= (k + 1) * RST_DLY);
      check("seq_rst_no", rst_no, exp_rst);
      check("seq_busy", busy_o, (j < NUM_CH * RST_DLY) ? 1 : 0);
      check("seq_clk", clk_o, (j % 2 == 0) ? {NUM_CH{1'b1}} : {NUM_CH{1'b0}});
    end
  endtask

  initial begin
    for (int k = 0; k < NUM_CH; k++) ack_cnt[k] = 0;
    tbl[0] = '{4, 10};
    tbl[1] = '{1, 4};
    tbl[2] = '{7, 16};
    tbl[3] = '{0, 2};
    tbl[4] = '{3, 8};
    tbl[5] = '{10, 22};

    // Reset values
    #2 rst_i = 1'b1;
    tick(); tick(); tick();
    check("rst_clk", clk_o, 0);
    check("rst_rst_no", rst_no, 0);
    check("rst_ack", div_ack_o, 0);
    check("rst_busy", busy_o, 1);

    // Partial sequence, then async reset mid-sequence with clk_o[0] high
    rst_i = 1'b0;
    seq_check(20);
    tick();
    check("pre_rst_no0", rst_no[0], 1);
    check("pre_clk0", clk_o[0], 1);
    #3 rst_i = 1'b1;
    #1;
    check("async_rst_no", rst_no, 0);
    check("async_clk", clk_o, 0);
    check("async_busy", busy_o, 1);
    check("async_ack", div_ack_o, 0);
    tick(); tick();

    // Full sequence again; test_mode_i must not matter in the default build
    test_mode_i = 1'b1;
    rst_i = 1'b0;
    e0 = cyc + 1;
    seq_check(55);
    test_mode_i = 1'b0;

    // Random ratio updates on channel 0 against a phase model:
    // after apply edge t0 with divide d, clk is high iff (t-t0) mod 2(d+1) >= d+1,
    // and the next apply is the first t0 + m*2(d+1) strictly after capture.
    d  = 0;
    t0 = e0 - 1;
    p  = 2;
    for (int r = 0; r < 12; r++) begin
      gap = $urandom_range(0, p + 2);
      for (int g = 0; g < gap; g++) begin
        tick();
        check("rnd_clk", clk_o[0], (((cyc - t0) % p) >= d + 1) ? 1 : 0);
        check("rnd_noack", div_ack_o[0], 0);
      end
      v = $urandom_range(0, 6);
      request(0, v);
      n = cyc;
      check("rnd_clk", clk_o[0], (((cyc - t0) % p) >= d + 1) ? 1 : 0);
      check("rnd_noack", div_ack_o[0], 0);
      a = t0 + p * ((n - t0) / p + 1);
      for (int i = 0; i <= p && cyc < a; i++) begin
        tick();
        check("rnd_clk", clk_o[0], (((cyc - t0) % p) >= d + 1) ? 1 : 0);
        check("rnd_ack", div_ack_o[0], (cyc == a) ? 1 : 0);
      end
      t0 = a;
      d  = v;
      p  = 2 * (v + 1);
    end

    // Table of divide values on channel 0
    cur_d = d;
    for (int r = 0; r < 6; r++) begin
      request(0, tbl[r].div);
      wait_ack(0, 2 * (cur_d + 1) + 2, lat);
      check("tbl_ack_in_time", (lat >= 1 && lat <= 2 * (cur_d + 1)) ? 1 : 0, 1);
      check("tbl_clk_at_ack", clk_o[0], 0);
      measure_run(0, 1'b0, 40, lo);
      measure_run(0, 1'b1, 40, hi);
      check("tbl_period", lo + hi, tbl[r].exp_period);
      check("tbl_duty", lo, tbl[r].exp_period / 2);
      cur_d = tbl[r].div;
    end

    // Two requests before the apply point: last wins, single ack
    request(1, 9);
    wait_ack(1, 4, lat);
    check("dbl_first_ack", (lat >= 1 && lat <= 2) ? 1 : 0, 1);
    div_i[DW +: DW] = 16'd7;
    div_valid_i[1] = 1'b1;
    tick();
    base = ack_cnt[1];
    div_i[DW +: DW] = 16'd3;
    tick();
    div_valid_i[1] = 1'b0;
    wait_ack(1, 22, lat);
    check("dbl_ack_seen", (lat >= 1) ? 1 : 0, 1);
    check("dbl_clk_at_ack", clk_o[1], 0);
    measure_run(1, 1'b0, 30, lo);
    measure_run(1, 1'b1, 30, hi);
    check("dbl_low", lo, 4);
    check("dbl_high", hi, 4);
    repeat (12) tick();
    check("dbl_ack_count", ack_cnt[1] - base, 1);

    // Enable gating on channel 2 with D=5
    request(2, 5);
    wait_ack(2, 4, lat);
    check("en_ack_seen", (lat >= 1) ? 1 : 0, 1);
    measure_run(2, 1'b0, 20, lo);
    check("en_low", lo, 6);
    tick(); tick();
    check("en_mid_high", clk_o[2], 1);
    clk_en_i[2] = 1'b0;
    measure_run(2, 1'b1, 20, hi);
    check("en_high_completes", hi, 4);
    flag = 1'b0;
    repeat (12) begin
      tick();
      flag = flag | clk_o[2];
    end
    check("en_stays_low", flag, 0);
    clk_en_i[2] = 1'b1;
    measure_run(2, 1'b0, 20, lo);
    check("en_first_rise", lo, 6);
    measure_run(2, 1'b1, 20, hi);
    check("en_high_after", hi, 6);
    clk_en_i[2] = 1'b0;
    tick(); tick();
    check("stop_low", clk_o[2], 0);
    request(2, 2);
    wait_ack(2, 4, lat);
    check("stop_ack_lat", lat, 1);
    check("stop_clk", clk_o[2], 0);
    clk_en_i[2] = 1'b1;
    measure_run(2, 1'b0, 20, lo);
    check("stop_new_rise", lo, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
